// File: rtl/reg8_loader.sv
// -----------------------------------------------------------------------------
// reg8_loader
//
// Streams a burst of BURST bytes from an upstream valid/ready source into an
// 8-entry register file, then (optionally) reads the same entries back and
// compares an 11-bit checksum of what was written against what was read.
//
// Optional feature macro: REG8_LOADER_VERIFY_EN
//   defined   : IDLE -> WRITE -> VERIFY -> DONE -> IDLE, readback checksum, err
//   undefined : IDLE -> WRITE -> DONE -> IDLE, rsel and err tied to 0
//
// Ports
//   clk       : clock, all state changes on rising edge
//   clr_n     : asynchronous active-low reset
//   start     : single-cycle burst request, sampled only in IDLE
//   in_valid  : upstream byte valid
//   in_data   : upstream byte
//   in_ready  : loader accepts a byte this cycle (high throughout WRITE)
//   en        : register-file write enable
//   wsel      : register-file write index
//   d         : register-file write data
//   rsel      : register-file read index (non-zero only in VERIFY)
//   q         : register-file read data, combinational from rsel
//   busy      : high in any state other than IDLE
//   done      : one-cycle pulse at burst completion
//   err       : readback checksum mismatch, held until the next start
// -----------------------------------------------------------------------------
module reg8_loader #(
  parameter int BURST = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       en,
  output logic [2:0] wsel,
  output logic [7:0] d,
  output logic [2:0] rsel,
  input  logic [7:0] q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] wptr_q, wptr_d;

`ifdef REG8_LOADER_VERIFY_EN
  logic [2:0]  rptr_q, rptr_d;
  logic [10:0] wsum_q, wsum_d;
  logic [10:0] rsum_q, rsum_d;
  logic        err_q, err_d;

  assign err = err_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rptr_q <= 3'd0;
      wsum_q <= 11'd0;
      rsum_q <= 11'd0;
      err_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wsum_q <= wsum_d;
      rsum_q <= rsum_d;
      err_q  <= err_d;
    end
  end
`else
  // Read data has no consumer without the readback check; fold it into a
  // sink so the port list stays identical across builds.
  logic unused_q;
  assign unused_q = ^q;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      wptr_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    in_ready = 1'b0;
    en       = 1'b0;
    wsel     = 3'd0;
    d        = 8'd0;
    rsel     = 3'd0;
    done     = 1'b0;
`ifdef REG8_LOADER_VERIFY_EN
    rptr_d   = rptr_q;
    wsum_d   = wsum_q;
    rsum_d   = rsum_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          wptr_d  = 3'd0;
`ifdef REG8_LOADER_VERIFY_EN
          rptr_d  = 3'd0;
          wsum_d  = 11'd0;
          rsum_d  = 11'd0;
          err_d   = 1'b0;
`endif
        end
      end

      WRITE: begin
        in_ready = 1'b1;
        en       = in_valid;
        wsel     = wptr_q;
        d        = in_data;
        if (in_valid) begin
          wptr_d = wptr_q + 3'd1;
`ifdef REG8_LOADER_VERIFY_EN
          wsum_d = wsum_q + {3'b000, in_data};
`endif
          // The last byte of the burst resets the pointer explicitly so a
          // short burst also leaves wptr at 0; for BURST=8 this coincides
          // with the natural 7->0 wrap.
          if (wptr_q == LAST_IDX) begin
            wptr_d = 3'd0;
`ifdef REG8_LOADER_VERIFY_EN
            rptr_d  = 3'd0;
            state_d = VERIFY;
`else
            state_d = DONE;
`endif
          end
        end
      end

      VERIFY: begin
`ifdef REG8_LOADER_VERIFY_EN
        rsel   = rptr_q;
        rsum_d = rsum_q + {3'b000, q};
        rptr_d = rptr_q + 3'd1;
        if (rptr_q == LAST_IDX) begin
          rptr_d  = 3'd0;
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        done    = 1'b1;
`ifdef REG8_LOADER_VERIFY_EN
        // Both sums are final here: the last read was added on the edge
        // that entered DONE.
        err_d   = (wsum_q != rsum_q);
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
